ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The module SHALL have a single clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  in  1  rising-edge clock for the EX/MEM pipeline register.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 wb_ctl  in  2  writeback control from ID/EX; carried through unchanged.
REQ-005 m_ctl  in  3  memory control from ID/EX: bit2 branch, bit1 memread, bit0 memwrite.
REQ-006 regdst  in  1  destination select: 1 selects instr_1511, 0 selects instr_2016.
REQ-007 alusrc  in  1  ALU operand B select: 1 selects s_extend, 0 selects rdata2.
REQ-008 aluop  in  2  ALU operation class from the decoder.
REQ-009 npc, rdata1, rdata2, s_extend  in  32 each  next PC, register operands, and sign-extended immediate.
REQ-010 instr_2016, instr_1511  in  5 each  rt and rd register fields.
REQ-011 flush  in  1  squashes the instruction being latched.
REQ-012 hold  in  1  stalls the EX/MEM register.
REQ-013 wb_ctlout  out  2  registered wb_ctl.
REQ-014 branch, memread, memwrite  out  1 each  registered m_ctl bits.
REQ-015 add_result  out  32  registered branch target.
REQ-016 zero  out  1  registered ALU-zero flag.
REQ-017 alu_result  out  32  registered ALU output.
REQ-018 rdata2out  out  32  registered rdata2, used as store data.
REQ-019 five_bit_muxout  out  5  registered destination register number.

Function
REQ-020 ALU control SHALL decode as follows:
- aluop 00: add.
- aluop 01: subtract.
- aluop 10: decode funct = s_extend[5:0]:
  - 100000 add
  - 100010 sub
  - 100100 and
  - 100101 or
  - 101010 slt
  - any other funct: result 0.
- aluop 11: result 0.
REQ-021 Add and sub SHALL be 32-bit modulo operations with no overflow detection or trap.
REQ-022 slt SHALL use a signed compare and produce 32'h00000001 when true, else 32'h00000000.
REQ-023 The zero flag SHALL be 1 exactly when the 32-bit ALU result equals 0.
REQ-024 The branch target SHALL be npc + (s_extend << 2), truncated to 32 bits (wraps).
REQ-025 ALU, ALU control, adder and muxes SHALL be combinational; all outputs SHALL be registered.
REQ-026 Latency SHALL be exactly 1 clk: inputs valid before edge N appear on outputs after edge N.
REQ-027 Register update priority per rising edge SHALL be rst > flush > hold > normal load.
REQ-028 On flush: wb_ctlout, branch, memread and memwrite SHALL load 0; all data outputs SHALL load normally.
REQ-029 On hold (without rst or flush): every output SHALL retain its prior value.
REQ-030 On normal load: every output SHALL take the value computed from the current inputs.
REQ-031 Simultaneous flush and hold SHALL act as flush.
REQ-032 There SHALL be no internal state besides the EX/MEM register.

Reset
REQ-033 While rst is high at a rising edge, every output SHALL be 0 at the next edge, regardless of flush or hold.
REQ-034 Reset asserted mid-stream SHALL discard the in-flight instruction; no partial control SHALL survive.
REQ-035 Outputs SHALL be 0 from the first reset edge until the first edge with rst low.

Verification
REQ-036 Reset check: rst=1 with hold=1 and nonzero inputs -> next cycle all outputs 0.
REQ-037 R-type add: aluop=10, alusrc=0, regdst=1, rdata1=5, rdata2=7, funct=100000, instr_1511=3 -> alu_result=12, zero=0, five_bit_muxout=3 after 1 clk.
REQ-038 Branch equal: aluop=01, m_ctl=100, rdata1=rdata2=32'h1234, npc=32'h100, s_extend=32'hFFFFFFFF -> zero=1, branch=1, add_result=32'hFC.
REQ-039 Signed slt: rdata1=32'hFFFFFFFF, rdata2=1, funct=101010 -> alu_result=1; swap the operands -> alu_result=0.
REQ-040 Load-word path: aluop=00, alusrc=1, regdst=0, rdata1=32'h1000, s_extend=8, m_ctl=010, instr_2016=9 -> alu_result=32'h1008, memread=1, five_bit_muxout=9.
REQ-041 Flush/hold priority:
- hold=1 for 2 cycles -> outputs frozen.
- flush=1 with hold=1 and wb_ctl=11 -> wb_ctlout=00, memwrite=0, data fields updated.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage of a classic five-stage MIPS-style pipeline, ending in the
// EX/MEM pipeline register.
//
// The ALU, ALU control, branch-target adder and operand/destination muxes are all
// combinational. Every output comes straight from the EX/MEM register, so results
// appear one clock after their inputs.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   wb_ctl[1:0], m_ctl[2:0]   writeback / memory control from ID/EX
//                             (m_ctl: bit2 branch, bit1 memread, bit0 memwrite)
//   regdst, alusrc, aluop     destination select, operand-B select, ALU op class
//   npc, rdata1, rdata2       next PC and register operands
//   s_extend                  sign-extended immediate; bits [5:0] hold funct
//   instr_2016, instr_1511    rt / rd register fields
//   flush                     squashes the control of the instruction being latched
//   hold                      freezes the EX/MEM register
//   wb_ctlout, branch, memread, memwrite, add_result, zero, alu_result,
//   rdata2out, five_bit_muxout   registered stage outputs
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  wb_ctl,
  input  logic [2:0]  m_ctl,
  input  logic        regdst,
  input  logic        alusrc,
  input  logic [1:0]  aluop,
  input  logic [31:0] npc,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  input  logic [31:0] s_extend,
  input  logic [4:0]  instr_2016,
  input  logic [4:0]  instr_1511,
  input  logic        flush,
  input  logic        hold,
  output logic [1:0]  wb_ctlout,
  output logic        branch,
  output logic        memread,
  output logic        memwrite,
  output logic [31:0] add_result,
  output logic        zero,
  output logic [31:0] alu_result,
  output logic [31:0] rdata2out,
  output logic [4:0]  five_bit_muxout
);

  // ALU operation selected by the ALU control decode.
  localparam logic [2:0] OpAdd  = 3'd0;
  localparam logic [2:0] OpSub  = 3'd1;
  localparam logic [2:0] OpAnd  = 3'd2;
  localparam logic [2:0] OpOr   = 3'd3;
  localparam logic [2:0] OpSlt  = 3'd4;
  localparam logic [2:0] OpZero = 3'd5;

  logic [2:0]  alu_op;
  logic [31:0] op_b;
  logic [31:0] alu_d;
  logic [31:0] target_d;
  logic [4:0]  dest_d;

  // Registered state.
  logic [1:0]  wb_ctl_q;
  logic [2:0]  m_ctl_q;
  logic [31:0] add_result_q;
  logic        zero_q;
  logic [31:0] alu_result_q;
  logic [31:0] rdata2_q;
  logic [4:0]  dest_q;

  // ALU control.
  always_comb begin
    alu_op = OpZero;
    unique case (aluop)
      2'b00: alu_op = OpAdd;
      2'b01: alu_op = OpSub;
      2'b10: begin
        case (s_extend[5:0])
          6'b100000: alu_op = OpAdd;
          6'b100010: alu_op = OpSub;
          6'b100100: alu_op = OpAnd;
          6'b100101: alu_op = OpOr;
          6'b101010: alu_op = OpSlt;
          default:   alu_op = OpZero;
        endcase
      end
      default: alu_op = OpZero;
    endcase
  end

  assign op_b = alusrc ? s_extend : rdata2;

  // ALU; add/sub wrap modulo 2^32 with no overflow reporting.
  always_comb begin
    alu_d = 32'h0;
    case (alu_op)
      OpAdd:   alu_d = rdata1 + op_b;
      OpSub:   alu_d = rdata1 - op_b;
      OpAnd:   alu_d = rdata1 & op_b;
      OpOr:    alu_d = rdata1 | op_b;
      OpSlt:   alu_d = ($signed(rdata1) < $signed(op_b)) ? 32'h1 : 32'h0;
      default: alu_d = 32'h0;
    endcase
  end

  assign target_d = npc + {s_extend[29:0], 2'b00};
  assign dest_d   = regdst ? instr_1511 : instr_2016;

  // EX/MEM register. Flush only kills the control bits so a squashed instruction
  // cannot write memory or the register file; its data fields are don't-care.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_ctl_q     <= 2'b00;
      m_ctl_q      <= 3'b000;
      add_result_q <= 32'h0;
      zero_q       <= 1'b0;
      alu_result_q <= 32'h0;
      rdata2_q     <= 32'h0;
      dest_q       <= 5'd0;
    end else if (flush || !hold) begin
      wb_ctl_q     <= flush ? 2'b00 : wb_ctl;
      m_ctl_q      <= flush ? 3'b000 : m_ctl;
      add_result_q <= target_d;
      zero_q       <= (alu_d == 32'h0);
      alu_result_q <= alu_d;
      rdata2_q     <= rdata2;
      dest_q       <= dest_d;
    end
  end

  assign wb_ctlout       = wb_ctl_q;
  assign branch          = m_ctl_q[2];
  assign memread         = m_ctl_q[1];
  assign memwrite        = m_ctl_q[0];
  assign add_result      = add_result_q;
  assign zero            = zero_q;
  assign alu_result      = alu_result_q;
  assign rdata2out       = rdata2_q;
  assign five_bit_muxout = dest_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage with hand-computed expected values.
module tb_ex_stage;

  logic        clk;
  logic        rst;
  logic [1:0]  wb_ctl;
  logic [2:0]  m_ctl;
  logic        regdst;
  logic        alusrc;
  logic [1:0]  aluop;
  logic [31:0] npc;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] s_extend;
  logic [4:0]  instr_2016;
  logic [4:0]  instr_1511;
  logic        flush;
  logic        hold;
  logic [1:0]  wb_ctlout;
  logic        branch;
  logic        memread;
  logic        memwrite;
  logic [31:0] add_result;
  logic        zero;
  logic [31:0] alu_result;
  logic [31:0] rdata2out;
  logic [4:0]  five_bit_muxout;

  int unsigned total;
  int unsigned bad;

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .wb_ctl          (wb_ctl),
    .m_ctl           (m_ctl),
    .regdst          (regdst),
    .alusrc          (alusrc),
    .aluop           (aluop),
    .npc             (npc),
    .rdata1          (rdata1),
    .rdata2          (rdata2),
    .s_extend        (s_extend),
    .instr_2016      (instr_2016),
    .instr_1511      (instr_1511),
    .flush           (flush),
    .hold            (hold),
    .wb_ctlout       (wb_ctlout),
    .branch          (branch),
    .memread         (memread),
    .memwrite        (memwrite),
    .add_result      (add_result),
    .zero            (zero),
    .alu_result      (alu_result),
    .rdata2out       (rdata2out),
    .five_bit_muxout (five_bit_muxout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".wb_ctlout"}, {30'd0, wb_ctlout}, 32'h0);
    check({tag, ".m_ctl"}, {29'd0, branch, memread, memwrite}, 32'h0);
    check({tag, ".add_result"}, add_result, 32'h0);
    check({tag, ".zero"}, {31'd0, zero}, 32'h0);
    check({tag, ".alu_result"}, alu_result, 32'h0);
    check({tag, ".rdata2out"}, rdata2out, 32'h0);
    check({tag, ".dest"}, {27'd0, five_bit_muxout}, 32'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset with hold and nonzero inputs: everything must clear.
    rst = 1'b1; hold = 1'b1; flush = 1'b0;
    wb_ctl = 2'b11; m_ctl = 3'b111; regdst = 1'b1; alusrc = 1'b0; aluop = 2'b00;
    npc = 32'h44; rdata1 = 32'h11; rdata2 = 32'h22; s_extend = 32'h20;
    instr_2016 = 5'd7; instr_1511 = 5'd8;
    @(negedge clk);
    step();
    step();
    check_all_zero("reset");

    // R-type add.
    rst = 1'b0; hold = 1'b0; flush = 1'b0;
    wb_ctl = 2'b10; m_ctl = 3'b000; regdst = 1'b1; alusrc = 1'b0; aluop = 2'b10;
    npc = 32'h40; rdata1 = 32'd5; rdata2 = 32'd7; s_extend = 32'h20;
    instr_2016 = 5'd4; instr_1511 = 5'd3;
    step();
    check("add.alu", alu_result, 32'd12);
    check("add.zero", {31'd0, zero}, 32'h0);
    check("add.dest", {27'd0, five_bit_muxout}, 32'd3);
    check("add.target", add_result, 32'hC0);
    check("add.wb", {30'd0, wb_ctlout}, 32'h2);
    check("add.rdata2out", rdata2out, 32'd7);

    // Branch equal via subtract; negative offset wraps the target.
    wb_ctl = 2'b00; m_ctl = 3'b100; aluop = 2'b01; alusrc = 1'b0;
    rdata1 = 32'h1234; rdata2 = 32'h1234; npc = 32'h100; s_extend = 32'hFFFF_FFFF;
    step();
    check("beq.zero", {31'd0, zero}, 32'h1);
    check("beq.branch", {31'd0, branch}, 32'h1);
    check("beq.target", add_result, 32'hFC);
    check("beq.alu", alu_result, 32'h0);

    // Signed slt both ways.
    m_ctl = 3'b000; aluop = 2'b10; s_extend = 32'h2A;
    rdata1 = 32'hFFFF_FFFF; rdata2 = 32'd1;
    step();
    check("slt.true", alu_result, 32'h1);
    rdata1 = 32'd1; rdata2 = 32'hFFFF_FFFF;
    step();
    check("slt.false", alu_result, 32'h0);
    check("slt.false.zero", {31'd0, zero}, 32'h1);

    // Remaining R-type functs and the zero-result classes.
    rdata1 = 32'd3; rdata2 = 32'd5; s_extend = 32'h22;
    step();
    check("sub.wrap", alu_result, 32'hFFFF_FFFE);
    rdata1 = 32'h0000_F0F0; rdata2 = 32'h0000_FF00; s_extend = 32'h24;
    step();
    check("and", alu_result, 32'h0000_F000);
    s_extend = 32'h25;
    step();
    check("or", alu_result, 32'h0000_FFF0);
    s_extend = 32'h3F;
    step();
    check("bad_funct", alu_result, 32'h0);
    check("bad_funct.zero", {31'd0, zero}, 32'h1);
    aluop = 2'b11; s_extend = 32'h20;
    step();
    check("aluop11", alu_result, 32'h0);
    aluop = 2'b00; rdata1 = 32'hFFFF_FFFF; rdata2 = 32'd1;
    step();
    check("add.wrap", alu_result, 32'h0);
    check("add.wrap.zero", {31'd0, zero}, 32'h1);

    // Load-word address path.
    wb_ctl = 2'b11; m_ctl = 3'b010; aluop = 2'b00; alusrc = 1'b1; regdst = 1'b0;
    rdata1 = 32'h1000; rdata2 = 32'hABCD; s_extend = 32'd8; npc = 32'h200;
    instr_2016 = 5'd9; instr_1511 = 5'd17;
    step();
    check("lw.alu", alu_result, 32'h1008);
    check("lw.memread", {31'd0, memread}, 32'h1);
    check("lw.dest", {27'd0, five_bit_muxout}, 32'd9);
    check("lw.target", add_result, 32'h220);
    check("lw.rdata2out", rdata2out, 32'hABCD);

    // Hold for two cycles with new inputs: nothing moves.
    hold = 1'b1;
    wb_ctl = 2'b01; m_ctl = 3'b001; regdst = 1'b1; rdata1 = 32'h5000; rdata2 = 32'h77;
    step();
    step();
    check("hold.alu", alu_result, 32'h1008);
    check("hold.memread", {31'd0, memread}, 32'h1);
    check("hold.memwrite", {31'd0, memwrite}, 32'h0);
    check("hold.dest", {27'd0, five_bit_muxout}, 32'd9);
    check("hold.wb", {30'd0, wb_ctlout}, 32'h3);
    check("hold.rdata2out", rdata2out, 32'hABCD);

    // Flush beats hold: control cleared, data loaded.
    flush = 1'b1; hold = 1'b1;
    wb_ctl = 2'b11; m_ctl = 3'b001; alusrc = 1'b0; aluop = 2'b00;
    rdata1 = 32'd1; rdata2 = 32'd2; regdst = 1'b1; instr_1511 = 5'd21;
    step();
    check("flush.wb", {30'd0, wb_ctlout}, 32'h0);
    check("flush.memwrite", {31'd0, memwrite}, 32'h0);
    check("flush.memread", {31'd0, memread}, 32'h0);
    check("flush.alu", alu_result, 32'd3);
    check("flush.rdata2out", rdata2out, 32'd2);
    check("flush.dest", {27'd0, five_bit_muxout}, 32'd21);

    // Back to normal load, then reset mid-stream with flush active.
    flush = 1'b0; hold = 1'b0; m_ctl = 3'b111;
    step();
    check("load.m_ctl", {29'd0, branch, memread, memwrite}, 32'h7);
    rst = 1'b1; flush = 1'b1;
    step();
    check_all_zero("midreset");
    rst = 1'b0; flush = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
